alct_cfg_ctrl: RTL and testbench

Sequences ALCT FPGA configuration from the TMB side: it waits for TMB power-up and VME load, times the ALCT configuration window, checks the ALCT DONE readback and issues hard-reset pulses with bounded retries. VME-initiated reloads also go through this block. It sits beside the startup logic in the VME block. Its `alct_hard_reset` output drives the ALCT hard-reset line, and its status bits are exposed in a VME status register.

---
 rtl/alct_cfg_ctrl_pkg.sv | 34 +++
 rtl/alct_msec_timer.sv | 53 +++++
 rtl/alct_cfg_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alct_cfg_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alct_cfg_ctrl_pkg.sv
// Shared types and constants for the ALCT configuration sequencer.
// ALCT_CFG_CTRL_DEBUG_EN selects the short debug ms period and the state-name port.
package alct_cfg_ctrl_pkg;

    localparam int DBG_MSEC_PERIOD = 5;
    localparam int RETRY_W         = 4;

    typedef enum logic [3:0] {
        ST_WAIT_UP  = 4'd0,
        ST_WAIT_VME = 4'd1,
        ST_PULSE    = 4'd2,
        ST_WAIT_CFG = 4'd3,
        ST_CHECK    = 4'd4,
        ST_OK       = 4'd5,
        ST_FAIL     = 4'd6
    } cfg_state_e;

    // Four-character ASCII tag shown on the debug display.
    function automatic logic [31:0] state_name(input cfg_state_e s);
        logic [31:0] r;
        case (s)
            ST_WAIT_UP:  r = "wup ";
            ST_WAIT_VME: r = "wvme";
            ST_PULSE:    r = "puls";
            ST_WAIT_CFG: r = "wcfg";
            ST_CHECK:    r = "chk ";
            ST_OK:       r = "ok  ";
            ST_FAIL:     r = "fail";
            default:     r = "????";
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alct_msec_timer.sv
// Millisecond prescaler plus saturating 16-bit millisecond counter.
// ALCT_CFG_CTRL_DEBUG_EN has no direct effect here; the period comes from the parent.
module alct_msec_timer #(
    parameter int PERIOD = 40078
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        en,
    input  logic        clr,
    output logic        msec_tick,
    output logic [15:0] msec_cnt
);

    localparam logic [15:0] PRE_LAST = 16'(PERIOD - 1);

    logic [15:0] pre_q, pre_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign msec_tick = tick_q;
    assign msec_cnt  = cnt_q;

endmodule

// File: rtl/alct_cfg_ctrl.sv
// ALCT FPGA configuration sequencer: startup wait, config window, DONE check, hard-reset retries.
// Define ALCT_CFG_CTRL_DEBUG_EN for a 5-clock ms period and the ctrl_sm_dsp state-name port.
module alct_cfg_ctrl
    import alct_cfg_ctrl_pkg::*;
#(
    parameter int MSEC_TICKS = 40078,
    parameter int PULSE_CLKS = 40,
    parameter int MAX_RETRY  = 3
) (
    input  logic               clock,
    input  logic               global_reset,
    input  logic               power_up,
    input  logic               vme_ready,
    input  logic               reload_req,
    input  logic               retry_en,
    input  logic               alct_cfg_done,
    input  logic [15:0]        cfg_delay,
    output logic               alct_hard_reset,
    output logic               ctrl_busy,
    output logic               ctrl_ok,
    output logic               ctrl_fail,
    output logic               done_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               msec_tick
`ifdef ALCT_CFG_CTRL_DEBUG_EN
    ,
    output logic [31:0]        ctrl_sm_dsp
`endif
);

    localparam int MS_PERIOD =
`ifdef ALCT_CFG_CTRL_DEBUG_EN
        DBG_MSEC_PERIOD;
`else
        MSEC_TICKS;
`endif

    localparam int                 PW          = $clog2(PULSE_CLKS + 1);
    localparam logic [PW-1:0]      PULSE_LAST  = PW'(PULSE_CLKS - 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

    cfg_state_e         state_q, state_d;
    logic               pwr_q, vme_q, reload_q;
    logic               done_m_q, done_s_q;
    logic [15:0]        delay_q, delay_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_q, lost_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic               busy_q, ok_q, fail_q, hrst_q;
    logic               timer_en, timer_clr;
    logic [15:0]        msec_cnt;

    // Timer and delay latch restart on every entry into the config window.
    assign timer_en  = (state_q == ST_WAIT_CFG);
    assign timer_clr = (state_d == ST_WAIT_CFG) && (state_q != ST_WAIT_CFG);
    assign delay_d   = timer_clr ? cfg_delay : delay_q;

    alct_msec_timer #(
        .PERIOD(MS_PERIOD)
    ) u_msec_timer (
        .clock       (clock),
        .global_reset(global_reset),
        .en          (timer_en),
        .clr         (timer_clr),
        .msec_tick   (msec_tick),
        .msec_cnt    (msec_cnt)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        pcnt_d  = '0;
        case (state_q)
            ST_WAIT_UP:  if (pwr_q) state_d = ST_WAIT_VME;
            // No startup pulse: the ALCT is reset together with the TMB.
            ST_WAIT_VME: if (vme_q) state_d = ST_WAIT_CFG;
            ST_PULSE: begin
                if (pcnt_q == PULSE_LAST) state_d = ST_WAIT_CFG;
                else                      pcnt_d  = pcnt_q + 1'b1;
            end
            ST_WAIT_CFG: if (msec_cnt >= delay_q) state_d = ST_CHECK;
            ST_CHECK: begin
                if (done_s_q) begin
                    state_d = ST_OK;
                end else if (retry_en && (retry_q < MAX_RETRY_C)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_OK: begin
                if (reload_q) begin
                    retry_d = '0;
                    lost_d  = 1'b0;
                    state_d = ST_PULSE;
                end else if (!done_s_q) begin
                    lost_d  = 1'b1;
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (reload_q) begin
                    retry_d = '0;
                    lost_d  = 1'b0;
                    state_d = ST_PULSE;
                end
            end
            default: state_d = ST_FAIL;
        endcase
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            state_q  <= ST_WAIT_UP;
            pwr_q    <= 1'b0;
            vme_q    <= 1'b0;
            reload_q <= 1'b0;
            done_m_q <= 1'b0;
            done_s_q <= 1'b0;
            delay_q  <= '0;
            retry_q  <= '0;
            lost_q   <= 1'b0;
            pcnt_q   <= '0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            hrst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwr_q    <= power_up;
            vme_q    <= vme_ready;
            reload_q <= reload_req;
            done_m_q <= alct_cfg_done;
            done_s_q <= done_m_q;
            delay_q  <= delay_d;
            retry_q  <= retry_d;
            lost_q   <= lost_d;
            pcnt_q   <= pcnt_d;
            busy_q   <= (state_q == ST_WAIT_UP) || (state_q == ST_WAIT_VME) ||
                        (state_q == ST_PULSE)   || (state_q == ST_WAIT_CFG) ||
                        (state_q == ST_CHECK);
            ok_q     <= (state_q == ST_OK);
            fail_q   <= (state_q == ST_FAIL);
            hrst_q   <= (state_q == ST_PULSE);
        end
    end

    assign alct_hard_reset = hrst_q;
    assign ctrl_busy       = busy_q;
    assign ctrl_ok         = ok_q;
    assign ctrl_fail       = fail_q;
    assign done_lost       = lost_q;
    assign retry_cnt       = retry_q;

`ifdef ALCT_CFG_CTRL_DEBUG_EN
    assign ctrl_sm_dsp = state_name(state_q);
`endif

endmodule

// File: tb/tb_alct_cfg_ctrl.sv
// Scoreboard bench for alct_cfg_ctrl: a timeline model queues expected pulses and
// status edges; a negedge monitor pops and compares them as the DUT produces them.
module tb_alct_cfg_ctrl;

    localparam int P     = 5;
    localparam int PCLK  = 40;
    localparam int MAXR  = 3;
    localparam int EV_PULSE = 1;
    localparam int EV_OK    = 2;
    localparam int EV_FAIL  = 3;

    logic        clock = 1'b0;
    logic        global_reset = 1'b1;
    logic        power_up = 1'b0;
    logic        vme_ready = 1'b0;
    logic        reload_req = 1'b0;
    logic        retry_en = 1'b0;
    logic        alct_cfg_done = 1'b0;
    logic [15:0] cfg_delay = 16'd0;
    logic        alct_hard_reset, ctrl_busy, ctrl_ok, ctrl_fail, done_lost, msec_tick;
    logic [3:0]  retry_cnt;
`ifdef ALCT_CFG_CTRL_DEBUG_EN
    logic [31:0] ctrl_sm_dsp;
`endif

    alct_cfg_ctrl #(
        .MSEC_TICKS(P),
        .PULSE_CLKS(PCLK),
        .MAX_RETRY (MAXR)
    ) dut (
        .clock          (clock),
        .global_reset   (global_reset),
        .power_up       (power_up),
        .vme_ready      (vme_ready),
        .reload_req     (reload_req),
        .retry_en       (retry_en),
        .alct_cfg_done  (alct_cfg_done),
        .cfg_delay      (cfg_delay),
        .alct_hard_reset(alct_hard_reset),
        .ctrl_busy      (ctrl_busy),
        .ctrl_ok        (ctrl_ok),
        .ctrl_fail      (ctrl_fail),
        .done_lost      (done_lost),
        .retry_cnt      (retry_cnt),
        .msec_tick      (msec_tick)
`ifdef ALCT_CFG_CTRL_DEBUG_EN
        ,
        .ctrl_sm_dsp    (ctrl_sm_dsp)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int stamp;
        int width;
        int retry;
        int lost;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  tick_tot = 0;
    int  exp_ticks = 0;
    int  rm = 0;
    int  lm = 0;
    bit  mok = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int stamp, input int width,
                           input int retry, input int lost);
        ev_t e;
        e.kind = kind; e.stamp = stamp; e.width = width; e.retry = retry; e.lost = lost;
        exp_q.push_back(e);
    endtask

    // Reference timeline: window of d ms, one-clock compare, one-clock CHECK,
    // outputs one clock behind the state.
    task automatic model_cfg(input int w_entry, input int d, input bit done, input bit ren);
        int w;
        int c;
        w = w_entry;
        forever begin
            exp_ticks += d;
            c = w + d * P + 1;
            if (done) begin
                push_ev(EV_OK, c + 2, 0, rm, lm);
                mok = 1'b1;
                break;
            end else if (ren && rm < MAXR) begin
                rm++;
                push_ev(EV_PULSE, c + 2, PCLK, rm, lm);
                w = c + 1 + PCLK;
            end else begin
                push_ev(EV_FAIL, c + 2, 0, rm, lm);
                mok = 1'b0;
                break;
            end
        end
    endtask

    task automatic got(input int kind, input int stamp, input int width,
                       input int retry, input int lost);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, 0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", stamp, e.stamp);
            if (kind == EV_PULSE) chk("pulse_width", width, e.width);
            chk("event_retry_cnt", retry, e.retry);
            chk("event_done_lost", lost, e.lost);
        end
    endtask

    // Monitor
    initial begin
        bit in_p = 1'b0;
        bit prev_ok = 1'b0;
        bit prev_fail = 1'b0;
        int p_start = 0, p_width = 0, p_retry = 0, p_lost = 0;
        forever begin
            @(negedge clock);
            if (global_reset) begin
                in_p = 1'b0; prev_ok = 1'b0; prev_fail = 1'b0;
            end else begin
                if (msec_tick) tick_tot++;
                if (alct_hard_reset) begin
                    if (!in_p) begin
                        in_p = 1'b1; p_start = cyc; p_width = 0;
                        p_retry = int'(retry_cnt); p_lost = int'(done_lost);
                    end
                    p_width++;
                end else if (in_p) begin
                    in_p = 1'b0;
                    got(EV_PULSE, p_start, p_width, p_retry, p_lost);
                end
                if (ctrl_ok && !prev_ok)
                    got(EV_OK, cyc, 0, int'(retry_cnt), int'(done_lost));
                if (ctrl_fail && !prev_fail)
                    got(EV_FAIL, cyc, 0, int'(retry_cnt), int'(done_lost));
                prev_ok = ctrl_ok;
                prev_fail = ctrl_fail;
            end
        end
    end

    task automatic tk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain(input int maxc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tk(1);
            n++;
        end
        chk({name, "_pending_events"}, exp_q.size(), 0);
        chk({name, "_msec_ticks"}, tick_tot, exp_ticks);
    endtask

    // Reload from OK/FAIL; a second request during the pulse must be ignored.
    task automatic do_reload(input int d, input bit done, input bit ren);
        int s;
        s = cyc;
        cfg_delay = 16'(d);
        retry_en = ren;
        reload_req = 1'b1;
        tk(1);
        reload_req = 1'b0;
        alct_cfg_done = done;
        rm = 0;
        lm = 0;
        push_ev(EV_PULSE, s + 3, PCLK, 0, 0);
        model_cfg(s + 2 + PCLK, d, done, ren);
        tk(8);
        reload_req = 1'b1;
        tk(1);
        reload_req = 1'b0;
    endtask

    task automatic do_lost();
        int s;
        s = cyc;
        alct_cfg_done = 1'b0;
        lm = 1;
        mok = 1'b0;
        push_ev(EV_FAIL, s + 4, 0, rm, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_hard_reset"}, int'(alct_hard_reset), 0);
        chk({name, "_busy"}, int'(ctrl_busy), 0);
        chk({name, "_ok"}, int'(ctrl_ok), 0);
        chk({name, "_fail"}, int'(ctrl_fail), 0);
        chk({name, "_done_lost"}, int'(done_lost), 0);
        chk({name, "_retry_cnt"}, int'(retry_cnt), 0);
        chk({name, "_msec_tick"}, int'(msec_tick), 0);
    endtask

    initial begin
        int s;
        int d;
        bit dn, ren;

        tk(3);
        chk_all_zero("reset");
        power_up = 1'b1;
        global_reset = 1'b0;
        tk(1);
        chk("busy_after_reset", int'(ctrl_busy), 1);
        tk(4);

        // Startup: no pulse, OK after the 3 ms window; mid-window delay change ignored.
        cfg_delay = 16'd3;
        alct_cfg_done = 1'b1;
        s = cyc;
        vme_ready = 1'b1;
        rm = 0; lm = 0;
        model_cfg(s + 2, 3, 1'b1, 1'b0);
        tk(5);
        cfg_delay = 16'd7;
        drain(200, "startup");
        chk("startup_ctrl_ok", int'(ctrl_ok), 1);

        // Zero delay reload: CHECK right after the window opens, no ms tick.
        do_reload(0, 1'b1, 1'b0);
        drain(200, "zero_delay");
        chk("zero_delay_retry_cnt", int'(retry_cnt), 0);

        // DONE lost while OK.
        do_lost();
        drain(20, "lost_done");
        chk("lost_done_flag", int'(done_lost), 1);

        // Retries exhausted with DONE stuck low; reload also clears done_lost.
        do_reload(1, 1'b0, 1'b1);
        drain(2000, "retry");
        chk("retry_final_cnt", int'(retry_cnt), rm);
        chk("retry_final_fail", int'(ctrl_fail), 1);
        chk("retry_final_done_lost", int'(done_lost), 0);

        for (int i = 0; i < 8; i++) begin
            if (mok && $urandom_range(0, 3) == 0) begin
                do_lost();
                drain(20, "rand_lost");
            end else begin
                d   = $urandom_range(0, 3);
                dn  = 1'($urandom_range(0, 1));
                ren = 1'($urandom_range(0, 1));
                do_reload(d, dn, ren);
                drain(2000, "rand_reload");
            end
            chk("rand_retry_cnt", int'(retry_cnt), rm);
            chk("rand_ctrl_ok", int'(ctrl_ok), int'(mok));
            chk("rand_ctrl_fail", int'(ctrl_fail), int'(!mok));
            chk("rand_done_lost", int'(done_lost), lm);
        end

        // Reset 10 clocks into a pulse: everything drops at once.
        if (!mok) alct_cfg_done = 1'b0;
        do_reload(1, 1'b1, 1'b0);
        tk(3);
        chk("pre_reset_pulse_high", int'(alct_hard_reset), 1);
        global_reset = 1'b1;
        #1;
        exp_q.delete();
        chk_all_zero("mid_pulse_reset");
        tk(3);
        global_reset = 1'b0;
        tk(1);
        chk("busy_after_second_reset", int'(ctrl_busy), 1);
        chk("post_reset_pulse_low", int'(alct_hard_reset), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
